// File: rtl/qupls_decode_rb_pipe_if.sv
// Handshake and payload bundle for the multi-lane Rb decode stage.
// master drives groups in and consumes decoded groups; slave is the decode stage.
interface qupls_decode_rb_pipe_if #(
    parameter int unsigned NLANES = 4,
    parameter int unsigned AREG_W = 9,
    parameter int unsigned OPC_W  = 7,
    parameter int unsigned OM_W   = 2
);
    logic                       flush;
    logic                       in_valid;
    logic                       in_ready;
    logic [NLANES-1:0]          in_lane_v;
    logic [OM_W-1:0]            in_om;
    logic [NLANES*OPC_W-1:0]    in_opcode;
    logic [NLANES*AREG_W-1:0]   in_arb;
    logic [NLANES-1:0]          in_regx;
    logic [NLANES-1:0]          in_has_immb;
    logic [NLANES-1:0]          in_immb_det;
    logic                       out_valid;
    logic                       out_ready;
    logic [NLANES-1:0]          out_lane_v;
    logic [NLANES*AREG_W-1:0]   out_rb;
    logic [NLANES-1:0]          out_rb_zero;

    modport master (
        output flush, in_valid, in_lane_v, in_om, in_opcode, in_arb, in_regx, in_has_immb,
               in_immb_det, out_ready,
        input  in_ready, out_valid, out_lane_v, out_rb, out_rb_zero
    );

    modport slave (
        input  flush, in_valid, in_lane_v, in_om, in_opcode, in_arb, in_regx, in_has_immb,
               in_immb_det, out_ready,
        output in_ready, out_valid, out_lane_v, out_rb, out_rb_zero
    );
endinterface

// File: rtl/qupls_decode_rb_pipe.sv
// Multi-lane architectural Rb decoder with SP banking, registered behind a main + skid
// entry so the upstream ready never depends combinationally on downstream ready.
module qupls_decode_rb_pipe #(
    parameter int unsigned           NLANES  = 4,
    parameter int unsigned           AREG_W  = 9,
    parameter int unsigned           OPC_W   = 7,
    parameter int unsigned           OM_W    = 2,
    parameter logic [OPC_W-1:0]      OP_RTD  = 7'd50,
    parameter logic [OPC_W-1:0]      OP_FLT3 = 7'd89,
    parameter int unsigned           SP_REG  = 63,
    parameter int unsigned           SP_BASE = 65
) (
    input logic                   clk,
    input logic                   rst,
    qupls_decode_rb_pipe_if.slave bus
);
    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e state_q, state_d;

    logic [NLANES-1:0]        dec_lane_v, dec_zero;
    logic [NLANES*AREG_W-1:0] dec_rb;
    logic [NLANES-1:0]        m_lane_v_q, m_zero_q, s_lane_v_q, s_zero_q;
    logic [NLANES*AREG_W-1:0] m_rb_q, s_rb_q;
    logic                     accept, drain;
    logic                     load_m_in, load_m_skid, load_s;

    // Returns {rb_zero, rb}; SP alias is banked by operating mode after the priority select.
    function automatic logic [AREG_W:0] decode_lane(
        input logic [OPC_W-1:0]  op,
        input logic [AREG_W-1:0] arb,
        input logic              regx,
        input logic              has_immb,
        input logic              immb_det,
        input logic [OM_W-1:0]   om
    );
        logic [AREG_W-1:0] ext;
        logic [AREG_W-1:0] rb;
        logic              zero;
        ext  = regx ? (arb | AREG_W'(64)) : arb;
        rb   = '0;
        zero = 1'b0;
        if (has_immb)           zero = 1'b1;
        else if (op == OP_RTD)  rb   = AREG_W'(SP_REG);
        else if (op == OP_FLT3) rb   = ext;
        else if (immb_det)      zero = 1'b1;
        else                    rb   = ext;
        if (rb == AREG_W'(SP_REG)) rb = AREG_W'(SP_BASE) + AREG_W'(om);
        return {zero, rb};
    endfunction

    always_comb begin
        dec_lane_v = bus.in_lane_v;
        dec_rb     = '0;
        dec_zero   = '0;
        for (int l = 0; l < int'(NLANES); l++) begin
            if (bus.in_lane_v[l]) begin
                {dec_zero[l], dec_rb[l*AREG_W +: AREG_W]} = decode_lane(
                    bus.in_opcode[l*OPC_W +: OPC_W], bus.in_arb[l*AREG_W +: AREG_W],
                    bus.in_regx[l], bus.in_has_immb[l], bus.in_immb_det[l], bus.in_om);
            end
        end
    end

    assign bus.in_ready    = !rst && (state_q != StTwo);
    assign bus.out_valid   = (state_q != StEmpty);
    assign bus.out_lane_v  = m_lane_v_q;
    assign bus.out_rb      = m_rb_q;
    assign bus.out_rb_zero = m_zero_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign drain  = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        if (bus.flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        load_m_in = 1'b1;
                        state_d   = StOne;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        load_m_in = 1'b1;
                    end else if (accept) begin
                        load_s  = 1'b1;
                        state_d = StTwo;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (drain) begin
                        load_m_skid = 1'b1;
                        state_d     = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            m_lane_v_q <= '0;
            m_rb_q     <= '0;
            m_zero_q   <= '0;
            s_lane_v_q <= '0;
            s_rb_q     <= '0;
            s_zero_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load_m_in) begin
                m_lane_v_q <= dec_lane_v;
                m_rb_q     <= dec_rb;
                m_zero_q   <= dec_zero;
            end else if (load_m_skid) begin
                m_lane_v_q <= s_lane_v_q;
                m_rb_q     <= s_rb_q;
                m_zero_q   <= s_zero_q;
            end
            if (load_s) begin
                s_lane_v_q <= dec_lane_v;
                s_rb_q     <= dec_rb;
                s_zero_q   <= dec_zero;
            end
        end
    end
endmodule

// File: tb/tb_qupls_decode_rb_pipe.sv
// Bench for qupls_decode_rb_pipe: hand-computed vector table, handshake corner sequences
// and a long random run, all checked against an in-order expected-result queue.
module tb_qupls_decode_rb_pipe;
    localparam int NL = 4;
    localparam int AW = 9;
    localparam int OW = 7;
    localparam int MW = 2;

    typedef struct packed {
        logic [NL-1:0]    lane_v;
        logic [NL*AW-1:0] rb;
        logic [NL-1:0]    zero;
    } res_t;

    typedef struct {
        logic [NL-1:0]    lv;
        logic [MW-1:0]    om;
        logic [NL*OW-1:0] op;
        logic [NL*AW-1:0] arb;
        logic [NL-1:0]    regx;
        logic [NL-1:0]    himm;
        logic [NL-1:0]    idet;
        logic [NL*AW-1:0] erb;
        logic [NL-1:0]    ez;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    res_t q[$];
    res_t exp_pending;
    vec_t tbl[8];

    always #5 clk = ~clk;

    qupls_decode_rb_pipe_if #(.NLANES(NL), .AREG_W(AW), .OPC_W(OW), .OM_W(MW)) bus ();

    qupls_decode_rb_pipe #(.NLANES(NL), .AREG_W(AW), .OPC_W(OW), .OM_W(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [NL*AW-1:0] rb4(input int a0, input int a1, input int a2,
                                              input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [NL*OW-1:0] op4(input int a0, input int a1, input int a2,
                                              input int a3);
        return {OW'(a3), OW'(a2), OW'(a1), OW'(a0)};
    endfunction

    // Reference decode written from the behavioural description with plain integers.
    function automatic res_t model(input vec_t v);
        res_t r;
        r.lane_v = v.lv;
        r.rb     = '0;
        r.zero   = '0;
        for (int l = 0; l < NL; l++) begin
            int a, op, res;
            logic z;
            if (!v.lv[l]) continue;
            a   = int'(v.arb[l*AW +: AW]);
            op  = int'(v.op[l*OW +: OW]);
            if (v.regx[l]) a = a | 64;
            res = 0;
            z   = 1'b0;
            if (v.himm[l])      z = 1'b1;
            else if (op == 50)  res = 63;
            else if (op == 89)  res = a;
            else if (v.idet[l]) z = 1'b1;
            else                res = a;
            if (res == 63) res = 65 + int'(v.om);
            r.rb[l*AW +: AW] = AW'(res);
            r.zero[l]        = z;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v, input res_t e);
        bus.in_valid    = 1'b1;
        bus.in_lane_v   = v.lv;
        bus.in_om       = v.om;
        bus.in_opcode   = v.op;
        bus.in_arb      = v.arb;
        bus.in_regx     = v.regx;
        bus.in_has_immb = v.himm;
        bus.in_immb_det = v.idet;
        exp_pending     = e;
    endtask

    function automatic res_t tbl_exp(input vec_t v);
        return {v.lv, v.erb, v.ez};
    endfunction

    // Checks handshake and head-of-queue data, then advances the model across one edge.
    task automatic tick();
        logic acc, drn;
        #1;
        chk("in_ready", 64'(bus.in_ready), 64'(!rst && q.size() < 2));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        if (q.size() > 0 && bus.out_valid) begin
            chk("out_lane_v", 64'(bus.out_lane_v), 64'(q[0].lane_v));
            chk("out_rb", 64'(bus.out_rb), 64'(q[0].rb));
            chk("out_rb_zero", 64'(bus.out_rb_zero), 64'(q[0].zero));
        end
        acc = bus.in_valid && !rst && q.size() < 2;
        drn = bus.out_ready && q.size() > 0;
        if (rst || bus.flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(exp_pending);
        end
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain_all();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8 && q.size() > 0; i++) tick();
        chk("drain_bound", 64'(q.size()), 64'(0));
    endtask

    initial begin
        vec_t v;
        rst             = 1'b1;
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_lane_v   = '0;
        bus.in_om       = '0;
        bus.in_opcode   = '0;
        bus.in_arb      = '0;
        bus.in_regx     = '0;
        bus.in_has_immb = '0;
        bus.in_immb_det = '0;
        bus.out_ready   = 1'b0;
        exp_pending     = '0;

        tbl[0] = '{4'b1111, 2'd0, op4(0, 0, 0, 0), rb4(5, 7, 0, 100), 4'b0001, 4'b0000,
                   4'b0000, rb4(69, 7, 0, 100), 4'b0000};
        for (int m = 0; m < 4; m++)
            tbl[1+m] = '{4'b1011, MW'(m), op4(50, 0, 0, 0), rb4(3, 63, 9, 63), 4'b1000,
                         4'b0000, 4'b0000, rb4(65 + m, 65 + m, 0, 127), 4'b0000};
        tbl[5] = '{4'b1111, 2'd2, op4(0, 0, 0, 0), rb4(63, 1, 2, 3), 4'b0000, 4'b0000,
                   4'b0000, rb4(67, 1, 2, 3), 4'b0000};
        tbl[6] = '{4'b1111, 2'd1, op4(50, 89, 0, 89), rb4(40, 12, 20, 3), 4'b1000, 4'b0001,
                   4'b0110, rb4(0, 12, 0, 67), 4'b0101};
        tbl[7] = '{4'b1011, 2'd3, op4(89, 0, 0, 0), rb4(63, 511, 8, 64), 4'b1010, 4'b0100,
                   4'b0000, rb4(68, 511, 0, 64), 4'b0000};

        repeat (2) @(negedge clk);
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_lane_v", 64'(bus.out_lane_v), 64'(0));
        chk("rst_rb", 64'(bus.out_rb), 64'(0));
        chk("rst_rb_zero", 64'(bus.out_rb_zero), 64'(0));
        rst = 1'b0;

        // Vector table: each group must appear exactly one cycle after acceptance.
        for (int i = 0; i < 8; i++) begin
            bus.out_ready = 1'b1;
            drive(tbl[i], tbl_exp(tbl[i]));
            tick();
            idle_in();
            tick();
        end

        // Backpressure: A then B fill main and skid, then drain in order.
        bus.out_ready = 1'b0;
        drive(tbl[0], tbl_exp(tbl[0]));
        tick();
        drive(tbl[6], tbl_exp(tbl[6]));
        tick();
        idle_in();
        #1 chk("full_in_ready", 64'(bus.in_ready), 64'(0));
        tick();
        drain_all();
        #1 chk("drained_in_ready", 64'(bus.in_ready), 64'(1));

        // Flush while full with a new group presented: that group must be dropped.
        bus.out_ready = 1'b0;
        drive(tbl[1], tbl_exp(tbl[1]));
        tick();
        drive(tbl[2], tbl_exp(tbl[2]));
        tick();
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        drive(tbl[7], tbl_exp(tbl[7]));
        tick();
        bus.flush = 1'b0;
        idle_in();
        bus.out_ready = 1'b1;
        repeat (3) tick();

        // Reset while holding one group.
        bus.out_ready = 1'b0;
        drive(tbl[5], tbl_exp(tbl[5]));
        tick();
        idle_in();
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_lane_v", 64'(bus.out_lane_v), 64'(0));
        chk("mid_rst_rb", 64'(bus.out_rb), 64'(0));
        chk("mid_rst_zero", 64'(bus.out_rb_zero), 64'(0));
        rst = 1'b0;
        tick();

        // Random traffic with random backpressure and rare flushes.
        for (int n = 0; n < 10000; n++) begin
            v.lv   = NL'($urandom);
            v.om   = MW'($urandom);
            v.regx = NL'($urandom);
            v.himm = NL'($urandom & $urandom);
            v.idet = NL'($urandom);
            for (int l = 0; l < NL; l++) begin
                int sel;
                sel = int'($urandom_range(0, 3));
                v.op[l*OW +: OW]  = (sel == 0) ? OW'(50) : (sel == 1) ? OW'(89) : OW'($urandom);
                v.arb[l*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'(63) : AW'($urandom);
            end
            v.erb = '0;
            v.ez  = '0;
            drive(v, model(v));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 199) == 0);
            tick();
        end
        bus.flush = 1'b0;
        idle_in();
        drain_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
